// File: rtl/wash_cycle_controller.sv
// Coin-operated washing machine sequencer: arms on coins, runs the soak/wash/rinse/spin
// phases enabled for the selected program, and supports lid pause, cancel/drain and refunds.
module wash_cycle_controller #(
    parameter int unsigned NUM_MODES = 3,
    parameter logic [4*NUM_MODES-1:0] MODE_MASK = 12'b1000_1110_1111,
    parameter int unsigned SOAK_TICKS  = 8,
    parameter int unsigned WASH_TICKS  = 16,
    parameter int unsigned RINSE_TICKS = 8,
    parameter int unsigned SPIN_TICKS  = 4,
    parameter int unsigned FILL_TICKS  = 2,
    parameter int unsigned COIN_COUNT  = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 lid,
    input  logic                 coin,
    input  logic                 cancel,
    input  logic [NUM_MODES-1:0] mode,
    output logic                 idle,
    output logic                 ready,
    output logic                 soak_operation,
    output logic                 wash_operation,
    output logic                 rinse_operation,
    output logic                 spin_operation,
    output logic                 coin_return,
    output logic                 water_intake,
    output logic                 done,
    output logic [CNT_W-1:0]     phase_remaining
);

    localparam int unsigned COIN_W = $clog2(COIN_COUNT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_SOAK  = 3'd2,
        S_WASH  = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_PAUSE = 3'd6
    } state_t;

    state_t             r_state, r_saved;
    logic [CNT_W-1:0]   r_timer;
    logic [COIN_W-1:0]  r_coins;
    logic               r_drain;
    logic [3:0]         r_mask;

    state_t             w_state, w_saved, w_next;
    logic [CNT_W-1:0]   w_timer, w_rem;
    logic [COIN_W-1:0]  w_coins;
    logic               w_drain, w_ret, w_done, w_water, w_onehot;
    logic [3:0]         w_mask, w_sel;

    function automatic logic [CNT_W-1:0] ticks_of(input state_t s);
        case (s)
            S_SOAK:  ticks_of = CNT_W'(SOAK_TICKS);
            S_WASH:  ticks_of = CNT_W'(WASH_TICKS);
            S_RINSE: ticks_of = CNT_W'(RINSE_TICKS);
            S_SPIN:  ticks_of = CNT_W'(SPIN_TICKS);
            default: ticks_of = '0;
        endcase
    endfunction

    // Lowest enabled phase in {spin,rinse,wash,soak} order; IDLE when none remain.
    function automatic state_t first_phase(input logic [3:0] m);
        if (m[0])      first_phase = S_SOAK;
        else if (m[1]) first_phase = S_WASH;
        else if (m[2]) first_phase = S_RINSE;
        else if (m[3]) first_phase = S_SPIN;
        else           first_phase = S_IDLE;
    endfunction

    function automatic state_t next_phase(input state_t s, input logic [3:0] m);
        case (s)
            S_SOAK:  next_phase = first_phase(m & 4'b1110);
            S_WASH:  next_phase = first_phase(m & 4'b1100);
            S_RINSE: next_phase = first_phase(m & 4'b1000);
            default: next_phase = S_IDLE;
        endcase
    endfunction

    function automatic logic is_wet(input state_t s);
        is_wet = (s == S_SOAK) || (s == S_WASH) || (s == S_RINSE);
    endfunction

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode[k]) begin
                w_sel = w_sel | MODE_MASK[4*k +: 4];
            end
        end
        w_onehot = (mode != '0) && ((mode & (mode - NUM_MODES'(1))) == '0);
    end

    // Next-state logic; priority inside each state is cancel > lid > timer > coin.
    always_comb begin
        w_state = r_state;
        w_saved = r_saved;
        w_timer = r_timer;
        w_coins = r_coins;
        w_drain = r_drain;
        w_mask  = r_mask;
        w_ret   = 1'b0;
        w_done  = 1'b0;
        w_next  = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (cancel) begin
                    w_ret   = coin || (r_coins != '0);
                    w_coins = '0;
                end else if (coin) begin
                    if (r_coins + COIN_W'(1) >= COIN_W'(COIN_COUNT)) begin
                        w_state = S_READY;
                        w_coins = '0;
                    end else begin
                        w_coins = r_coins + COIN_W'(1);
                    end
                end
            end
            S_READY: begin
                w_ret = coin;
                if (cancel) begin
                    w_ret   = 1'b1;
                    w_state = S_IDLE;
                end else if (w_onehot && !lid && (w_sel != 4'b0000)) begin
                    w_mask  = w_sel;
                    w_state = first_phase(w_sel);
                    w_timer = ticks_of(first_phase(w_sel));
                end
            end
            S_SOAK, S_WASH, S_RINSE, S_SPIN: begin
                w_ret  = coin;
                w_next = next_phase(r_state, r_mask);
                if (cancel && (r_state != S_SPIN)) begin
                    w_state = S_SPIN;
                    w_timer = CNT_W'(SPIN_TICKS);
                end else if (lid) begin
                    w_state = S_PAUSE;
                    w_saved = r_state;
                end else if (r_timer <= CNT_W'(1)) begin
                    w_state = w_next;
                    w_timer = ticks_of(w_next);
                    if (w_next == S_IDLE) begin
                        w_done = 1'b1;
                        w_mask = '0;
                    end
                end else begin
                    w_timer = r_timer - CNT_W'(1);
                end
            end
            S_PAUSE: begin
                w_ret = coin;
                if (cancel) begin
                    w_drain = 1'b1;
                end
                if (!lid) begin
                    if (cancel || r_drain) begin
                        w_state = S_SPIN;
                        w_timer = CNT_W'(SPIN_TICKS);
                        w_drain = 1'b0;
                    end else begin
                        w_state = r_saved;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    // Output values as seen after the next edge; fill runs while elapsed < FILL_TICKS.
    always_comb begin
        w_rem   = '0;
        w_water = 1'b0;
        if ((w_state == S_SPIN) || is_wet(w_state)) begin
            w_rem = w_timer;
        end
        if (is_wet(w_state)) begin
            w_water = w_timer > (ticks_of(w_state) - CNT_W'(FILL_TICKS));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_saved         <= S_IDLE;
            r_timer         <= '0;
            r_coins         <= '0;
            r_drain         <= 1'b0;
            r_mask          <= '0;
            idle            <= 1'b1;
            ready           <= 1'b0;
            soak_operation  <= 1'b0;
            wash_operation  <= 1'b0;
            rinse_operation <= 1'b0;
            spin_operation  <= 1'b0;
            coin_return     <= 1'b0;
            water_intake    <= 1'b0;
            done            <= 1'b0;
            phase_remaining <= '0;
        end else begin
            r_state         <= w_state;
            r_saved         <= w_saved;
            r_timer         <= w_timer;
            r_coins         <= w_coins;
            r_drain         <= w_drain;
            r_mask          <= w_mask;
            idle            <= (w_state == S_IDLE);
            ready           <= (w_state == S_READY);
            soak_operation  <= (w_state == S_SOAK);
            wash_operation  <= (w_state == S_WASH);
            rinse_operation <= (w_state == S_RINSE);
            spin_operation  <= (w_state == S_SPIN);
            coin_return     <= w_ret;
            water_intake    <= w_water;
            done            <= w_done;
            phase_remaining <= w_rem;
        end
    end

endmodule

// File: tb/tb_wash_cycle_controller.sv
// Scoreboard bench for wash_cycle_controller: directed stimulus pushes hand-computed
// per-cycle output vectors; a monitor pops and compares them after each clock edge.
module tb_wash_cycle_controller;

    localparam int ST_IDLE  = 0;
    localparam int ST_READY = 1;
    localparam int ST_SOAK  = 2;
    localparam int ST_WASH  = 3;
    localparam int ST_RINSE = 4;
    localparam int ST_SPIN  = 5;
    localparam int ST_PAUSE = 6;

    typedef struct packed {
        logic       idle;
        logic       ready;
        logic       soak;
        logic       wash;
        logic       rinse;
        logic       spin;
        logic       ret;
        logic       water;
        logic       dn;
        logic [7:0] rem;
    } outv_t;

    typedef struct {
        int    at;
        int    id;
        outv_t v;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n, lid, coin, cancel;
    logic [2:0] mode;
    logic       idle, ready, soak_operation, wash_operation, rinse_operation, spin_operation;
    logic       coin_return, water_intake, done;
    logic [7:0] phase_remaining;

    exp_t       q[$];
    int         edge_cnt    = 0;
    int         tests       = 0;
    int         fails       = 0;
    int         step_id     = 0;
    int         wash_active = 0;
    logic [2:0] cur_mode    = 3'b000;

    wash_cycle_controller dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .lid             (lid),
        .coin            (coin),
        .cancel          (cancel),
        .mode            (mode),
        .idle            (idle),
        .ready           (ready),
        .soak_operation  (soak_operation),
        .wash_operation  (wash_operation),
        .rinse_operation (rinse_operation),
        .spin_operation  (spin_operation),
        .coin_return     (coin_return),
        .water_intake    (water_intake),
        .done            (done),
        .phase_remaining (phase_remaining)
    );

    always #5 clock = ~clock;

    function automatic outv_t mk(input int st, input int rem, input bit wt, input bit rt, input bit dn);
        outv_t v;
        v = '0;
        case (st)
            ST_IDLE:  v.idle  = 1'b1;
            ST_READY: v.ready = 1'b1;
            ST_SOAK:  v.soak  = 1'b1;
            ST_WASH:  v.wash  = 1'b1;
            ST_RINSE: v.rinse = 1'b1;
            ST_SPIN:  v.spin  = 1'b1;
            default:  v.idle  = 1'b0;
        endcase
        v.water = wt;
        v.ret   = rt;
        v.dn    = dn;
        v.rem   = 8'(rem);
        return v;
    endfunction

    function automatic outv_t actual();
        outv_t a;
        a = {idle, ready, soak_operation, wash_operation, rinse_operation, spin_operation,
             coin_return, water_intake, done, phase_remaining};
        return a;
    endfunction

    // One stimulus cycle: apply inputs mid-cycle and queue the outputs expected after the next edge.
    task automatic drive(input bit c, input bit x, input bit l, input logic [2:0] m, input outv_t e);
        exp_t t;
        @(negedge clock);
        coin   = c;
        cancel = x;
        lid    = l;
        mode   = m;
        if (wash_operation && !l) wash_active++;
        t.at = edge_cnt + 1;
        t.id = step_id;
        t.v  = e;
        q.push_back(t);
        step_id++;
    endtask

    // Quiet cycles through a phase, showing remaining counts hi down to lo.
    task automatic phase_run(input int st, input int ticks, input int hi, input int lo);
        bit wet;
        wet = (st == ST_SOAK) || (st == ST_WASH) || (st == ST_RINSE);
        for (int r = hi; r >= lo; r--) begin
            drive(1'b0, 1'b0, 1'b0, cur_mode, mk(st, r, wet && ((ticks - r) < 2), 1'b0, 1'b0));
        end
    endtask

    task automatic chk_vec(input string name, input outv_t e);
        outv_t a;
        a = actual();
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, a, e);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    initial begin : monitor
        exp_t  e;
        outv_t a;
        forever begin
            @(posedge clock);
            edge_cnt++;
            #2;
            while (q.size() > 0 && q[0].at <= edge_cnt) begin
                e = q.pop_front();
                a = actual();
                tests++;
                if ((e.at != edge_cnt) || (a !== e.v)) begin
                    fails++;
                    $display("FAIL step%0d edge%0d: got %b required %b", e.id, edge_cnt, a, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        reset_n = 1'b0;
        lid     = 1'b0;
        coin    = 1'b0;
        cancel  = 1'b0;
        mode    = 3'b000;
        #12;
        chk_vec("reset_state", mk(ST_IDLE, 0, 0, 0, 0));
        @(negedge clock);
        reset_n = 1'b1;

        // Full program, mode 0: soak 8, wash 16, rinse 8, spin 4, done.
        cur_mode = 3'b001;
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_READY, 0, 0, 0, 0));
        drive(0, 0, 0, cur_mode, mk(ST_SOAK, 8, 1, 0, 0));
        phase_run(ST_SOAK, 8, 7, 1);
        phase_run(ST_WASH, 16, 16, 1);
        phase_run(ST_RINSE, 8, 8, 1);
        phase_run(ST_SPIN, 4, 4, 1);
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 1));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));

        // Non-one-hot mode and open lid hold READY; spin-only program.
        drive(1, 0, 0, 3'b011, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, 3'b011, mk(ST_READY, 0, 0, 0, 0));
        drive(0, 0, 0, 3'b011, mk(ST_READY, 0, 0, 0, 0));
        drive(0, 0, 1, 3'b100, mk(ST_READY, 0, 0, 0, 0));
        cur_mode = 3'b100;
        drive(0, 0, 0, cur_mode, mk(ST_SPIN, 4, 0, 0, 0));
        phase_run(ST_SPIN, 4, 3, 1);
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 1));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));

        // Coin / cancel / refund handling.
        cur_mode = 3'b000;
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(0, 1, 0, cur_mode, mk(ST_IDLE, 0, 0, 1, 0));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(0, 1, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 1, 0, cur_mode, mk(ST_IDLE, 0, 0, 1, 0));
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 1, 0, cur_mode, mk(ST_IDLE, 0, 0, 1, 0));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_READY, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_READY, 0, 0, 1, 0));
        drive(0, 1, 0, cur_mode, mk(ST_IDLE, 0, 0, 1, 0));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));

        // Coin during wash, lid pause at remaining 10, cancel in rinse -> drain spin.
        cur_mode    = 3'b001;
        wash_active = 0;
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_READY, 0, 0, 0, 0));
        drive(0, 0, 0, cur_mode, mk(ST_SOAK, 8, 1, 0, 0));
        phase_run(ST_SOAK, 8, 7, 1);
        phase_run(ST_WASH, 16, 16, 14);
        drive(1, 0, 0, cur_mode, mk(ST_WASH, 13, 0, 1, 0));
        phase_run(ST_WASH, 16, 12, 10);
        repeat (5) drive(0, 0, 1, cur_mode, mk(ST_PAUSE, 0, 0, 0, 0));
        drive(0, 0, 0, cur_mode, mk(ST_WASH, 10, 0, 0, 0));
        phase_run(ST_WASH, 16, 9, 1);
        phase_run(ST_RINSE, 8, 8, 6);
        drive(0, 1, 0, cur_mode, mk(ST_SPIN, 4, 0, 0, 0));
        phase_run(ST_SPIN, 4, 3, 1);
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 1));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        chk_int("wash_active_cycles", wash_active, 16);

        // Cancel while paused drains on lid close; cancel in spin ignored; pause inside spin.
        cur_mode = 3'b010;
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_READY, 0, 0, 0, 0));
        drive(0, 0, 0, cur_mode, mk(ST_WASH, 16, 1, 0, 0));
        drive(0, 0, 1, cur_mode, mk(ST_PAUSE, 0, 0, 0, 0));
        drive(0, 1, 1, cur_mode, mk(ST_PAUSE, 0, 0, 0, 0));
        drive(0, 0, 1, cur_mode, mk(ST_PAUSE, 0, 0, 0, 0));
        drive(0, 0, 0, cur_mode, mk(ST_SPIN, 4, 0, 0, 0));
        drive(0, 1, 0, cur_mode, mk(ST_SPIN, 3, 0, 0, 0));
        drive(0, 0, 1, cur_mode, mk(ST_PAUSE, 0, 0, 0, 0));
        drive(0, 0, 0, cur_mode, mk(ST_SPIN, 3, 0, 0, 0));
        phase_run(ST_SPIN, 4, 2, 1);
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 1));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));

        // Asynchronous reset during rinse, then a clean restart from IDLE.
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_READY, 0, 0, 0, 0));
        drive(0, 0, 0, cur_mode, mk(ST_WASH, 16, 1, 0, 0));
        phase_run(ST_WASH, 16, 15, 1);
        phase_run(ST_RINSE, 8, 8, 7);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk_vec("async_reset", mk(ST_IDLE, 0, 0, 0, 0));
        @(negedge clock);
        @(negedge clock);
        chk_vec("reset_hold", mk(ST_IDLE, 0, 0, 0, 0));
        reset_n = 1'b1;
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));
        drive(1, 0, 0, cur_mode, mk(ST_READY, 0, 0, 0, 0));
        drive(0, 1, 0, cur_mode, mk(ST_IDLE, 0, 0, 1, 0));
        drive(0, 0, 0, cur_mode, mk(ST_IDLE, 0, 0, 0, 0));

        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations never checked", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
